// File: rtl/seq_stage_ctrl.sv
// Y86 sequential stage sequencer: one-hot stage enables, PC strobe, status latch, perf counters.
// Optional single-step pause after each retirement: define SEQ_CTRL_SINGLE_STEP_EN.
module seq_stage_ctrl #(
    parameter int CNT_W   = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             invalid_instr,
    input  logic             memory_error,
    input  logic             dmem_error,
    input  logic             step_req,
    output logic [4:0]       stage_en,
    output logic             pc_we,
    output logic [3:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0100;
    localparam logic [3:0] STAT_INS = 4'b1000;
    localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_STOP
    } state_t;

    state_t     state, state_n;
    logic [3:0] mem_cnt;
    logic [3:0] stat_n;
    logic       mem_last;
    logic       count_en;
    logic       retire;

    assign mem_last = (mem_cnt == MEM_LAST);

`ifndef SEQ_CTRL_SINGLE_STEP_EN
    logic step_unused;
    assign step_unused = step_req;
`endif

    always_comb begin
        state_n  = state;
        stat_n   = stat;
        stage_en = 5'b00000;
        pc_we    = 1'b0;
        busy     = 1'b0;
        count_en = 1'b0;
        retire   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                stage_en = 5'b00001;
                busy     = 1'b1;
                count_en = 1'b1;
                state_n  = S_DECODE;
                // Priority: instruction address error, then bad icode, then halt
                if (memory_error) begin
                    state_n = S_STOP;
                    stat_n  = STAT_ADR;
                end else if (invalid_instr) begin
                    state_n = S_STOP;
                    stat_n  = STAT_INS;
                end else if (halt) begin
                    state_n = S_STOP;
                    stat_n  = STAT_HLT;
                end
            end
            S_DECODE: begin
                stage_en = 5'b00010;
                busy     = 1'b1;
                count_en = 1'b1;
                state_n  = S_EXECUTE;
            end
            S_EXECUTE: begin
                stage_en = 5'b00100;
                busy     = 1'b1;
                count_en = 1'b1;
                state_n  = S_MEMORY;
            end
            S_MEMORY: begin
                stage_en = 5'b01000;
                busy     = 1'b1;
                count_en = 1'b1;
                if (mem_last) begin
                    if (dmem_error) begin
                        state_n = S_STOP;
                        stat_n  = STAT_ADR;
                    end else begin
                        state_n = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                stage_en = 5'b10000;
                busy     = 1'b1;
                count_en = 1'b1;
                state_n  = S_PCUPD;
            end
            S_PCUPD: begin
                pc_we    = 1'b1;
                busy     = 1'b1;
                count_en = 1'b1;
                retire   = 1'b1;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
                state_n  = S_PAUSE;
`else
                state_n  = S_FETCH;
`endif
            end
`ifdef SEQ_CTRL_SINGLE_STEP_EN
            S_PAUSE: begin
                busy = 1'b1;
                if (step_req) state_n = S_FETCH;
            end
`endif
            S_STOP: begin
                state_n = S_STOP;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            stat  <= STAT_AOK;
        end else begin
            state <= state_n;
            stat  <= stat_n;
        end
    end

    // Memory hold counter runs only inside MEMORY and is cleared on exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cnt <= 4'd0;
        end else if (state == S_MEMORY && !mem_last) begin
            mem_cnt <= mem_cnt + 4'd1;
        end else begin
            mem_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (count_en && cycle_count != '1)
                cycle_count <= cycle_count + CNT_W'(1);
            if (retire && instr_count != '1)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus randomized
// instruction streams against a per-instruction timeline model.
module tb_seq_stage_ctrl;

    localparam int CW = 32;
    localparam int ML = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, halt = 1'b0, invalid_instr = 1'b0;
    logic memory_error = 1'b0, dmem_error = 1'b0, step_req = 1'b0;
    logic [4:0]    stage_en;
    logic          pc_we, busy;
    logic [3:0]    stat;
    logic [CW-1:0] cycle_count, instr_count;

    logic [4:0] se_s;
    logic       we_s, busy_s;
    logic [3:0] stat_s;
    logic [2:0] cc_s, ic_s;

    logic reset3 = 1'b1, start3 = 1'b0, dmem3 = 1'b0, zero = 1'b0;
    logic [4:0]    se3;
    logic          we3, busy3;
    logic [3:0]    stat3;
    logic [CW-1:0] cc3, ic3;

    seq_stage_ctrl #(.CNT_W(CW), .MEM_LAT(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .invalid_instr(invalid_instr), .memory_error(memory_error),
        .dmem_error(dmem_error), .step_req(step_req),
        .stage_en(stage_en), .pc_we(pc_we), .stat(stat), .busy(busy),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    seq_stage_ctrl #(.CNT_W(3), .MEM_LAT(ML)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .invalid_instr(invalid_instr), .memory_error(memory_error),
        .dmem_error(dmem_error), .step_req(step_req),
        .stage_en(se_s), .pc_we(we_s), .stat(stat_s), .busy(busy_s),
        .cycle_count(cc_s), .instr_count(ic_s)
    );

    seq_stage_ctrl #(.CNT_W(CW), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset3), .start(start3), .halt(zero),
        .invalid_instr(zero), .memory_error(zero),
        .dmem_error(dmem3), .step_req(zero),
        .stage_en(se3), .pc_we(we3), .stat(stat3), .busy(busy3),
        .cycle_count(cc3), .instr_count(ic3)
    );

    int checks = 0;
    int errors = 0;
    int exp_cyc, exp_ret, pcwe_seen;
    logic [3:0] exp_stat;
    bit stopped;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_cyc"}, cycle_count, exp_cyc);
        chk({tag, "_ret"}, instr_count, exp_ret);
        chk({tag, "_cyc_sat"}, cc_s, sat7(exp_cyc));
        chk({tag, "_ret_sat"}, ic_s, sat7(exp_ret));
    endtask

    task automatic chk_stop(input string tag);
        chk({tag, "_en"}, stage_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, pc_we, 0);
        chk({tag, "_stat"}, stat, exp_stat);
        chk_counts(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cyc = 0; exp_ret = 0; exp_stat = 4'b0001;
        stopped = 0; pcwe_seen = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // ferr = {memory_error, invalid_instr, halt}; entered with DUT in FETCH
    task automatic do_instr(input logic [2:0] ferr, input bit dmem,
                            input bit poke_start);
        chk("fetch_en", stage_en, 5'b00001);
        chk("fetch_busy", busy, 1);
        chk_counts("fetch");
        {memory_error, invalid_instr, halt} = ferr;
        step();
        {memory_error, invalid_instr, halt} = 3'b000;
        exp_cyc++;
        if (ferr != 3'b000) begin
            exp_stat = ferr[2] ? 4'b0100 : (ferr[1] ? 4'b1000 : 4'b0010);
            stopped = 1;
            chk_stop("fstop");
            return;
        end
        chk("dec_en", stage_en, 5'b00010);
        step_req = 1'b1;
        start = poke_start;
        step();
        step_req = 1'b0;
        start = 1'b0;
        exp_cyc++;
        chk("exe_en", stage_en, 5'b00100);
        chk("exe_stat", stat, exp_stat);
        step();
        exp_cyc++;
        for (int m = 0; m < ML; m++) begin
            chk("mem_en", stage_en, 5'b01000);
            if (m == ML - 1) dmem_error = dmem;
            step();
            dmem_error = 1'b0;
            exp_cyc++;
        end
        if (dmem) begin
            exp_stat = 4'b0100;
            stopped = 1;
            chk_stop("dstop");
            return;
        end
        chk("wb_en", stage_en, 5'b10000);
        chk("wb_we", pc_we, 0);
        step();
        exp_cyc++;
        chk("pcu_we", pc_we, 1);
        chk("pcu_en", stage_en, 0);
        chk("pcu_busy", busy, 1);
        if (pc_we === 1'b1) pcwe_seen++;
        step();
        exp_cyc++;
        exp_ret++;
        chk("ret_cnt", instr_count, exp_ret);
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        repeat (10) begin
            chk("pause_en", stage_en, 0);
            chk("pause_busy", busy, 1);
            chk("pause_we", pc_we, 0);
            chk("pause_cyc", cycle_count, exp_cyc);
            step();
        end
        step_req = 1'b1;
        step();
        step_req = 1'b0;
`endif
    endtask

    initial begin
        exp_cyc = 0; exp_ret = 0; exp_stat = 4'b0001;
        stopped = 0; pcwe_seen = 0;
        @(negedge clk);
        chk("rst_en", stage_en, 0);
        chk("rst_we", pc_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stat", stat, 4'b0001);
        chk_counts("rst");
        reset = 1'b0;
        reset3 = 1'b0;
        step();
        step();
        chk("idle_en", stage_en, 0);
        chk("idle_busy", busy, 0);

        // Three clean instructions, halt on the fourth fetch
        do_start();
        do_instr(3'b000, 0, 0);
        do_instr(3'b000, 0, 1);
        do_instr(3'b000, 0, 0);
        do_instr(3'b001, 0, 0);
        chk("halt_stat", stat, 4'b0010);
        chk("halt_ret", instr_count, 3);
        chk("halt_cyc", cycle_count, 19);
        chk("halt_pcwe", pcwe_seen, 3);
        start = 1'b1;
        step_req = 1'b1;
        step();
        start = 1'b0;
        step_req = 1'b0;
        step();
        chk_stop("stop_ign");

        do_reset();
        do_start();
        do_instr(3'b011, 0, 0);
        chk("ins_stat", stat, 4'b1000);
        do_reset();
        do_start();
        do_instr(3'b111, 0, 0);
        chk("adr_stat", stat, 4'b0100);

        // Asynchronous reset in EXECUTE of the second instruction
        do_reset();
        do_start();
        do_instr(3'b000, 0, 0);
        chk("r2_fetch", stage_en, 5'b00001);
        step();
        step();
        chk("r2_exe", stage_en, 5'b00100);
        reset = 1'b1;
        #1;
        chk("ar_en", stage_en, 0);
        chk("ar_we", pc_we, 0);
        chk("ar_busy", busy, 0);
        chk("ar_stat", stat, 4'b0001);
        chk("ar_cyc", cycle_count, 0);
        chk("ar_ret", instr_count, 0);
        do_reset();
        do_start();
        do_instr(3'b000, 0, 0);
        chk("ar_again", instr_count, 1);

        // Randomized instruction streams
        do_reset();
        do_start();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] fe;
            bit dm;
            fe = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            dm = ($urandom_range(0, 9) == 0);
            do_instr(fe, dm, bit'($urandom_range(0, 1)));
            if (stopped) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk_stop("rnd_stop");
                do_reset();
                do_start();
            end
        end

        // MEM_LAT=3 instance with a data-memory fault
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("m3_f", se3, 5'b00001);
        step();
        chk("m3_d", se3, 5'b00010);
        step();
        chk("m3_e", se3, 5'b00100);
        step();
        for (int m = 0; m < 3; m++) begin
            chk("m3_mem", se3, 5'b01000);
            chk("m3_we", we3, 0);
            if (m == 2) dmem3 = 1'b1;
            step();
            dmem3 = 1'b0;
        end
        chk("m3_en", se3, 0);
        chk("m3_stat", stat3, 4'b0100);
        chk("m3_we_end", we3, 0);
        chk("m3_busy", busy3, 0);
        chk("m3_ret", ic3, 0);
        chk("m3_cyc", cc3, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Stage sequencer and status controller for the Y86 sequential processor. Replaces the free-running testbench clock toggling and `$finish`-on-error logic with a synthesizable Moore FSM. The FSM enables fetch, decode, execute, memory and writeback one stage at a time, then issues the PC write strobe. It latches the architectural status code (AOK/HLT/ADR/INS) and stops the machine on any exception. It sits at the processor top, between the clock/reset source and the stage modules, and also exposes cycle and retired-instruction counters.

## Interface
- CNT_W, 32, width of both performance counters
- MEM_LAT, 1, number of cycles the memory stage is held (legal 1..15)

- clk  in  1  processor clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- start  in  1  single-cycle pulse; begins execution from IDLE
- halt  in  1  fetch reports halt instruction; sampled only in FETCH
- invalid_instr  in  1  fetch reports bad icode; sampled only in FETCH
- memory_error  in  1  fetch reports instruction-memory address error; sampled only in FETCH
- dmem_error  in  1  data-memory address error; sampled only in last MEMORY cycle
- step_req  in  1  single-step advance pulse (used only with SEQ_CTRL_SINGLE_STEP_EN)
- stage_en  out  5  one-hot stage enable: bit0 fetch, bit1 decode, bit2 execute, bit3 memory, bit4 writeback
- pc_we  out  1  PC register load strobe (PC <= PC_updated)
- stat  out  4  status: 0001 AOK, 0010 HLT, 0100 ADR, 1000 INS
- busy  out  1  high while an instruction is in flight or paused
- cycle_count  out  CNT_W  cycles spent in FETCH..PCUPD
- instr_count  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, PAUSE (macro only), STOP.
- IDLE: if start=1, go to FETCH; otherwise stay in IDLE.
- FETCH: check fetch errors in priority order memory_error > invalid_instr > halt.
  - If any is set, go to STOP and latch stat = 0100, 1000 or 0010 respectively.
  - Otherwise go to DECODE.
- DECODE → EXECUTE → MEMORY, unconditionally.
- MEMORY is held for MEM_LAT cycles using an internal 4-bit counter.
  - On the last cycle, dmem_error=1 sends the FSM to STOP with stat=0100. Writeback and PC update are suppressed.
  - Otherwise go to WRITEBACK.
- WRITEBACK → PCUPD.
- PCUPD: retire the instruction (instr_count+1), then go to FETCH (or PAUSE, see Configuration).
- STOP is terminal: start and step_req are ignored, stat is held, and only reset leaves it.
- Outputs are Moore, decoded from the state register:
  - stage_en has exactly one bit set in FETCH..WRITEBACK and is 0 elsewhere.
  - pc_we=1 only in PCUPD.
  - busy=1 in FETCH..PCUPD and PAUSE.
- cycle_count increments on every cycle spent in FETCH..PCUPD.
- Both counters saturate at 2^CNT_W−1; they do not wrap.
- start while busy or in STOP is ignored.
- A halt instruction does not retire: instr_count is not incremented and pc_we is not asserted.

## Timing
- Reset values: state IDLE, stage_en 0, pc_we 0, busy 0, stat 0001, cycle_count 0, instr_count 0, MEMORY sub-counter 0.
- start sampled high at edge k: stage_en=00001 and busy=1 from edge k until edge k+1.
- Instruction latency is 5+MEM_LAT cycles (6 with default MEM_LAT=1), edge of FETCH entry to edge of next FETCH entry.
- pc_we is high for exactly one cycle per retired instruction.
- Fetch error inputs must be valid during the FETCH cycle. stat updates at the edge leaving FETCH, and stage_en=0 from that same edge.
- Reset asserted mid-instruction clears all state asynchronously. No partial pc_we pulse survives.
- Inputs halt, invalid_instr, memory_error and dmem_error are don't-care outside their sampling states.

## Configuration
- SEQ_CTRL_SINGLE_STEP_EN defined: PCUPD goes to PAUSE.
  - PAUSE holds busy=1, stage_en=0, pc_we=0, and cycle_count does not increment.
  - A step_req=1 sample in PAUSE moves the FSM to FETCH on the next edge. step_req in any other state is ignored.
- Not defined: PAUSE state is absent, PCUPD goes directly to FETCH, and step_req is unconnected internally.

## Test plan
- Reset, start pulse, 3 clean instructions, halt=1 on 4th FETCH (MEM_LAT=1) → stage_en walks 1,2,4,8,16 per instruction and pc_we pulses 3 times. Final stat=0010, instr_count=3, cycle_count=19, busy=0.
- halt=1 and invalid_instr=1 in the same FETCH → stat=1000. memory_error=1 added as well → stat=0100.
- dmem_error=1 on MEMORY with MEM_LAT=3 → memory stage spans 3 cycles, then STOP with stat=0100. No WRITEBACK, no pc_we, instr_count unchanged.
- Reset asserted during EXECUTE of the 2nd instruction → outputs return to reset values immediately (stage_en=0, stat=0001, counters 0). A new start pulse re-enters FETCH.
- start pulses while busy and while in STOP → no effect on state, counters or stat.
- With SEQ_CTRL_SINGLE_STEP_EN: after 1st PCUPD, FSM idles in PAUSE for 10 cycles with cycle_count fixed at 6. step_req pulse → FETCH next edge. Without the macro, the same step_req stimulus has no effect.
